// File: rtl/ro_freq_counter_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency counter.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } meas_state_e;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_WIN_W         = 16;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SYNC_STAGES   = 2;

  // Bits needed to hold a down-counter loaded with n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_freq_counter_if.sv
// Control/result bundle between the sensor readout logic, the oscillator and the counter.
interface ro_freq_counter_if
  import ro_meas_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
);
  logic             i_Start;
  logic             i_Sel;
  logic [WIN_W-1:0] i_Win_len;
  logic             i_RO_out;
  logic             o_RO_enable;
  logic             o_RO_sel;
  logic             o_Busy;
  logic             o_Done;
  logic [CNT_W-1:0] o_Count;
  logic             o_Overflow;

  modport master (
    output i_Start, i_Sel, i_Win_len, i_RO_out,
    input  o_RO_enable, o_RO_sel, o_Busy, o_Done, o_Count, o_Overflow
  );

  modport slave (
    input  i_Start, i_Sel, i_Win_len, i_RO_out,
    output o_RO_enable, o_RO_sel, o_Busy, o_Done, o_Count, o_Overflow
  );
endinterface

// File: rtl/ro_freq_counter_sync_rise_detect.sv
// Brings the asynchronous oscillator output into i_Clk and flags one-cycle rising edges.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic ro_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus the previous synchronized value for edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ro_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/ro_freq_counter.sv
// Enables the selected ring oscillator, waits for it to settle, then counts its
// rising edges over a programmable window and reports a saturated result.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WIN_W         = DEF_WIN_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input logic              i_Clk,
  input logic              i_Rst_n,
  ro_freq_counter_if.slave bus
);

  localparam int SET_W = cnt_width(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  meas_state_e      state_r;
  meas_state_e      state_s;
  logic             start_s;
  logic             to_count_s;
  logic             to_done_s;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_s;
  logic             ovf_s;

  logic [WIN_W-1:0] win_r;
  logic [WIN_W-1:0] win_cnt_r;
  logic [SET_W-1:0] settle_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             ro_en_r;
  logic             ro_sel_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] count_out_r;
  logic             ovf_out_r;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .ro_in  (bus.i_RO_out),
    .rise   (rise_s)
  );

  // Next-state decode; the window counter holds remaining cycles minus one.
  always_comb begin
    state_s    = state_r;
    start_s    = 1'b0;
    to_count_s = 1'b0;
    to_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_Start) begin
          state_s = SETTLE;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_r == '0) begin
          if (win_r == '0) begin
            state_s   = DONE;
            to_done_s = 1'b1;
          end else begin
            state_s    = COUNT;
            to_count_s = 1'b1;
          end
        end else begin
          state_s = SETTLE;
        end
      end
      COUNT: begin
        if (win_cnt_r == '0) begin
          state_s   = DONE;
          to_done_s = 1'b1;
        end else begin
          state_s = COUNT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Saturating edge counter; overflow flags an edge that arrived while already full.
  always_comb begin
    cnt_s = cnt_r;
    ovf_s = ovf_r;
    if ((state_r == COUNT) && rise_s) begin
      if (&cnt_r) begin
        ovf_s = 1'b1;
      end else begin
        cnt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_s = cnt_r;
      ovf_s = ovf_r;
    end
  end

  // FSM state, status strobes and oscillator controls.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ro_en_r  <= 1'b0;
      ro_sel_r <= 1'b0;
      win_r    <= '0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= to_done_s;
      if (start_s) begin
        ro_en_r  <= 1'b1;
        ro_sel_r <= bus.i_Sel;
        win_r    <= bus.i_Win_len;
      end else if (to_done_s) begin
        ro_en_r <= 1'b0;
      end else begin
        ro_en_r <= ro_en_r;
      end
    end
  end

  // Settle and window down-counters plus the working edge count.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      settle_cnt_r <= '0;
      win_cnt_r    <= '0;
      cnt_r        <= '0;
      ovf_r        <= 1'b0;
    end else begin
      if (start_s) begin
        settle_cnt_r <= SETTLE_LOAD;
        cnt_r        <= '0;
        ovf_r        <= 1'b0;
      end else begin
        cnt_r <= cnt_s;
        ovf_r <= ovf_s;
        if ((state_r == SETTLE) && (settle_cnt_r != '0)) begin
          settle_cnt_r <= settle_cnt_r - SET_W'(1);
        end else begin
          settle_cnt_r <= settle_cnt_r;
        end
      end
      if (to_count_s) begin
        win_cnt_r <= win_r - WIN_W'(1);
      end else if ((state_r == COUNT) && (win_cnt_r != '0)) begin
        win_cnt_r <= win_cnt_r - WIN_W'(1);
      end else begin
        win_cnt_r <= win_cnt_r;
      end
    end
  end

  // Published result, captured with the final-cycle edge included.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_out_r <= '0;
      ovf_out_r   <= 1'b0;
    end else if (to_done_s) begin
      count_out_r <= cnt_s;
      ovf_out_r   <= ovf_s;
    end else begin
      count_out_r <= count_out_r;
      ovf_out_r   <= ovf_out_r;
    end
  end

  assign bus.o_RO_enable = ro_en_r;
  assign bus.o_RO_sel    = ro_sel_r;
  assign bus.o_Busy      = busy_r;
  assign bus.o_Done      = done_r;
  assign bus.o_Count     = count_out_r;
  assign bus.o_Overflow  = ovf_out_r;

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Measurement controller directly downstream of the 127-stage HVT NOR ring oscillator.
- Drives the oscillator's enable and select inputs, and counts rising edges of its output over a programmable window of system-clock cycles.
- Presents the saturated count to the sensor readout logic with a one-cycle done strobe.
- Single clock domain: the oscillator output is synchronized and edge-detected in i_Clk. System constraint: oscillator frequency must stay below f(i_Clk)/2.5.

Parameters:
- CNT_W, 16, width of the edge counter and o_Count.
- WIN_W, 16, width of the window-length input, in i_Clk cycles.
- SETTLE_CYCLES, 8, cycles after the oscillator is enabled during which edges are ignored. Legal range is at least SYNC_STAGES+1.
- SYNC_STAGES, 2, number of synchronizer flops on i_RO_out. Minimum 2.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Start  in  1  measurement request, sampled only in IDLE.
- i_Sel  in  1  oscillator select, latched at start.
- i_Win_len  in  WIN_W  count window in i_Clk cycles, latched at start.
- i_RO_out  in  1  raw oscillator output (asynchronous).
- o_RO_enable  out  1  to oscillator i_Enable.
- o_RO_sel  out  1  to oscillator i_Sel.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle strobe; o_Count and o_Overflow are valid from this cycle.
- o_Count  out  CNT_W  edges counted in the last measurement.
- o_Overflow  out  1  last measurement saturated.

Behaviour:
- Reset: asynchronous, active-low. All outputs, the synchronizer, the edge register and the counters clear to 0. State goes to IDLE.
- Reset mid-measurement: o_RO_enable drops immediately, no o_Done is issued, and the previous result is lost (o_Count=0).
- States: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - o_RO_enable=0.
  - On i_Start=1: latch i_Win_len to win_r, latch i_Sel to o_RO_sel, set o_RO_enable=1, clear the edge counter and overflow flag, load the settle counter, go to SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles.
  - The synchronizer and edge register run; detected edges are discarded.
  - Exit to COUNT, or directly to DONE when win_r==0.
- COUNT:
  - Lasts exactly win_r cycles.
  - Each cycle with rise = sync_out & ~sync_prev increments the counter.
  - At all-ones the counter holds and the overflow flag sets; the flag stays set until the next start.
  - In the cycle the window counter expires: the last edge is still counted, o_RO_enable is cleared registered (low in the DONE cycle), go to DONE.
- DONE:
  - Lasts 1 cycle.
  - o_Done=1; o_Count and o_Overflow update from the internal registers in this same cycle.
  - Go to IDLE.
- Latency: with the i_Start sample edge as cycle 0, o_Done is high in cycle SETTLE_CYCLES+win_r+1.
- o_Count and o_Overflow hold their values until the next DONE.
- i_Start while o_Busy=1 is ignored, not queued.
- i_Start held high: a new measurement starts on the IDLE cycle after DONE.
- o_RO_sel holds its latched value after a measurement; it changes only at the next start.
- Edges are counted only inside the window; edges arriving in the synchronizer pipeline after COUNT are dropped.
- Edge-count accuracy for any oscillator phase: floor or ceil of win_r/period.

Decomposition:
- Package ro_meas_pkg holds the state enum (IDLE, SETTLE, COUNT, DONE) and the default width constants.
- One sub-module, sync_rise_detect: SYNC_STAGES flop synchronizer plus previous-value register. Outputs rise, with reset to 0 on i_Rst_n.
- Top level holds the FSM, settle/window down-counters and the saturating edge counter.

Test Plan:
- Reset check: i_Rst_n=0 with random inputs -> all outputs 0. Release with i_Start=0 -> outputs stay 0 for 20 cycles.
- Basic measurement: i_RO_out synchronous square wave, period 4 clk; i_Win_len=40, i_Sel=1, pulse i_Start -> o_RO_sel=1 and o_RO_enable=1 from cycle 1; o_Done in cycle 49 (SETTLE_CYCLES=8); o_Count=10; o_Overflow=0; o_RO_enable=0 in cycle 49.
- Overflow: CNT_W=4, period 4, i_Win_len=80 -> o_Count=15, o_Overflow=1. A following run with i_Win_len=8 -> o_Count=2, o_Overflow=0.
- Zero window: i_Win_len=0 -> o_Done in cycle 9, o_Count=0. Edges toggling during SETTLE are not counted.
- Busy and back-to-back: i_Start pulsed again during COUNT -> ignored, single o_Done. i_Start held high -> second start exactly one cycle after o_Done, with new i_Win_len latched.
- Reset mid-COUNT: assert i_Rst_n=0 at cycle 20 of a 40-cycle window -> o_RO_enable=0 immediately, no o_Done, o_Count=0. A later measurement completes normally with the correct count.
